// File: rtl/force_accumulate_sequencer.sv
// -----------------------------------------------------------------------------
// force_accumulate_sequencer
//
// Time-multiplexes a single force calculator across all objects of the n-body
// simulator. Each accepted step updates one subject object (obj_sel). The
// sequencer walks other_sel over every object and sums the x/y forces on the
// subject, skipping the self pair. It then pulses commit for one cycle so the
// position/velocity bank can write the subject's new state.
//
// Ports
//   clock        system clock, all state on the rising edge
//   reset        synchronous active-high reset
//   step         request one update of obj_sel (sampled every cycle)
//   freeze       1 = new steps are not accepted; a running update completes
//   x_force_in   x force on obj_sel from other_sel (combinational, same cycle)
//   y_force_in   y force on obj_sel from other_sel
//   busy         update in progress (ACCUM or COMMIT), registered
//   obj_sel      subject object index (bank read/write address)
//   other_sel    other object index presented to the force calculator
//   x_force_sum  accumulated x force, final while commit=1, held until next start
//   y_force_sum  accumulated y force, same timing as x_force_sum
//   commit       one-cycle pulse: bank writes obj_sel this edge
//   frame_done   one-cycle pulse with commit when obj_sel is the last object
//   overrun      sticky: a step arrived while busy; cleared only by reset
// -----------------------------------------------------------------------------
module force_accumulate_sequencer #(
    parameter int N_OBJ   = 8,
    parameter int IDX_W   = 3,
    parameter int FORCE_W = 14
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               step,
    input  logic               freeze,
    input  logic [FORCE_W-1:0] x_force_in,
    input  logic [FORCE_W-1:0] y_force_in,
    output logic               busy,
    output logic [IDX_W-1:0]   obj_sel,
    output logic [IDX_W-1:0]   other_sel,
    output logic [FORCE_W-1:0] x_force_sum,
    output logic [FORCE_W-1:0] y_force_sum,
    output logic               commit,
    output logic               frame_done,
    output logic               overrun
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic             busy_reg;
    logic             commit_reg;
    logic             frame_done_reg;
    logic             overrun_reg;
    logic [IDX_W-1:0] obj_sel_reg;
    logic [IDX_W-1:0] other_sel_reg;

    logic start;
    logic last_other;
    logic accum_add;

    assign start      = (state_reg == IDLE) && step && !freeze;
    assign last_other = (other_sel_reg == LAST_IDX);
    // The self pair contributes nothing; the calculator output for it is ignored.
    assign accum_add  = (state_reg == ACCUM) && (other_sel_reg != obj_sel_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (last_other) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            commit_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            obj_sel_reg    <= '0;
            other_sel_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            busy_reg       <= (state_next != IDLE);
            // commit is raised on the edge that ends the final ACCUM cycle,
            // so it is high exactly during the COMMIT cycle.
            commit_reg     <= (state_reg == ACCUM) && last_other;
            frame_done_reg <= (state_reg == ACCUM) && last_other && (obj_sel_reg == LAST_IDX);
            if (step && (state_reg != IDLE)) begin
                overrun_reg <= 1'b1;
            end
            if (start) begin
                other_sel_reg <= '0;
            end else if ((state_reg == ACCUM) && !last_other) begin
                other_sel_reg <= other_sel_reg + 1'b1;
            end
            // N_OBJ is a power of two, so the natural wrap takes N_OBJ-1 back to 0.
            if (state_reg == COMMIT) begin
                obj_sel_reg <= obj_sel_reg + 1'b1;
            end
        end
    end

    // One accumulator lane per axis: lane 0 = x, lane 1 = y.
    // Plain modular add, no saturation.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            logic [FORCE_W-1:0] force_sel;
            logic [FORCE_W-1:0] sum_reg;

            assign force_sel = (gi == 0) ? x_force_in : y_force_in;

            always_ff @(posedge clock) begin
                if (reset) begin
                    sum_reg <= '0;
                end else if (start) begin
                    sum_reg <= '0;
                end else if (accum_add) begin
                    sum_reg <= sum_reg + force_sel;
                end
            end
        end
    endgenerate

    assign busy        = busy_reg;
    assign commit      = commit_reg;
    assign frame_done  = frame_done_reg;
    assign overrun     = overrun_reg;
    assign obj_sel     = obj_sel_reg;
    assign other_sel   = other_sel_reg;
    assign x_force_sum = g_axis[0].sum_reg;
    assign y_force_sum = g_axis[1].sum_reg;

endmodule

// File: tb/tb_force_accumulate_sequencer.sv
module tb_force_accumulate_sequencer;

    localparam int N = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        step = 1'b0;
    logic        freeze = 1'b0;
    logic [13:0] x_force_in;
    logic [13:0] y_force_in;
    logic        busy;
    logic [2:0]  obj_sel;
    logic [2:0]  other_sel;
    logic [13:0] x_force_sum;
    logic [13:0] y_force_sum;
    logic        commit;
    logic        frame_done;
    logic        overrun;

    int checks = 0;
    int failures = 0;
    int exp_obj = 0;

    // Force tables indexed [subject][other]; emulate a zero-latency calculator.
    logic [13:0] x_tab [N][N];
    logic [13:0] y_tab [N][N];

    assign x_force_in = x_tab[obj_sel][other_sel];
    assign y_force_in = y_tab[obj_sel][other_sel];

    force_accumulate_sequencer #(.N_OBJ(8), .IDX_W(3), .FORCE_W(14)) dut (
        .clock(clock), .reset(reset), .step(step), .freeze(freeze),
        .x_force_in(x_force_in), .y_force_in(y_force_in),
        .busy(busy), .obj_sel(obj_sel), .other_sel(other_sel),
        .x_force_sum(x_force_sum), .y_force_sum(y_force_sum),
        .commit(commit), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: the sum of all forces on obj from every other object, mod 2^14.
    function automatic logic [13:0] exp_sum(input int axis, input int obj);
        int s = 0;
        for (int j = 0; j < N; j++) begin
            if (j != obj) s += int'(axis == 0 ? x_tab[obj][j] : y_tab[obj][j]);
        end
        return 14'(s);
    endfunction

    task automatic fill_const(input logic [13:0] xv, input logic [13:0] yv,
                              input logic [13:0] xd, input logic [13:0] yd);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                x_tab[i][j] = (i == j) ? xd : xv;
                y_tab[i][j] = (i == j) ? yd : yv;
            end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                x_tab[i][j] = 14'($urandom);
                y_tab[i][j] = 14'($urandom);
            end
    endtask

    task automatic apply_reset();
        reset = 1'b1; step = 1'b0; freeze = 1'b0;
        tick(); tick();
        reset = 1'b0;
        exp_obj = 0;
    endtask

    // Starts an update from an IDLE cycle and checks it to completion.
    // ovr: ACCUM cycle index (1..N) where an extra step pulse is injected, 0 = none.
    // frz: ACCUM cycle index from which freeze is held high, 0 = never.
    task automatic run_update(input string name, input logic [13:0] ex, input logic [13:0] ey,
                              input int ovr, input int frz);
        int bad_accum = 0;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (commit !== 1'b0 || busy !== 1'b1) bad_accum++;
            step = (i == ovr);
            freeze = (frz != 0) && (i >= frz);
            tick();
        end
        step = 1'b0;
        checks++;
        if (bad_accum != 0) begin
            failures++;
            $display("FAIL %s accum_phase: %0d bad cycles, required 0", name, bad_accum);
        end
        checks++;
        if (commit !== 1'b1 || frame_done !== (exp_obj == N - 1)) begin
            failures++;
            $display("FAIL %s commit_pulse: commit=%b frame_done=%b, required 1/%0d",
                     name, commit, frame_done, exp_obj == N - 1);
        end
        checks++;
        if (x_force_sum !== ex || y_force_sum !== ey) begin
            failures++;
            $display("FAIL %s sums: x=%h y=%h, required x=%h y=%h",
                     name, x_force_sum, y_force_sum, ex, ey);
        end
        checks++;
        if (obj_sel !== 3'(exp_obj)) begin
            failures++;
            $display("FAIL %s obj_sel_commit: %0d, required %0d", name, obj_sel, exp_obj);
        end
        tick();
        exp_obj = (exp_obj + 1) % N;
        freeze = 1'b0;
        checks++;
        if (commit !== 1'b0 || busy !== 1'b0 || obj_sel !== 3'(exp_obj)) begin
            failures++;
            $display("FAIL %s after_commit: commit=%b busy=%b obj_sel=%0d, required 0/0/%0d",
                     name, commit, busy, obj_sel, exp_obj);
        end
        $display("update %s: obj=%0d x_sum=%h y_sum=%h", name, (exp_obj + N - 1) % N,
                 ex, ey);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (busy !== 1'b0 || commit !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: busy=%b commit=%b fd=%b ovr=%b, required 0000",
                     busy, commit, frame_done, overrun);
        end
        checks++;
        if (obj_sel !== 3'd0 || other_sel !== 3'd0 || x_force_sum !== 14'd0 || y_force_sum !== 14'd0) begin
            failures++;
            $display("FAIL reset_values: obj=%0d other=%0d x=%h y=%h, required all 0",
                     obj_sel, other_sel, x_force_sum, y_force_sum);
        end
        $display("reset: checked");
    endtask

    task automatic test_basic();
        fill_const(14'd1, 14'h3FFF, 14'd1, 14'h3FFF);
        run_update("basic", 14'd7, 14'h3FF9, 0, 0);
    endtask

    task automatic test_self_skip();
        fill_const(14'd0, 14'd0, 14'h0100, 14'h0100);
        run_update("self_skip", 14'd0, 14'd0, 0, 0);
    endtask

    task automatic test_wrap();
        fill_random();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (i != j) x_tab[i][j] = 14'h1FFF;
        run_update("wrap", 14'h1FF9, exp_sum(1, exp_obj), 0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            fill_random();
            run_update("random", exp_sum(0, exp_obj), exp_sum(1, exp_obj), 0, 0);
        end
    endtask

    task automatic test_freeze_idle();
        int started = 0;
        step = 1'b1; freeze = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy !== 1'b0) started++;
        end
        step = 1'b0; freeze = 1'b0;
        checks++;
        if (started != 0 || overrun !== 1'b0 || obj_sel !== 3'(exp_obj)) begin
            failures++;
            $display("FAIL freeze_idle: busy_cycles=%0d overrun=%b obj=%0d, required 0/0/%0d",
                     started, overrun, obj_sel, exp_obj);
        end
        $display("freeze_idle: busy_cycles=%0d overrun=%b", started, overrun);
    endtask

    task automatic test_freeze_mid();
        fill_random();
        run_update("freeze_mid", exp_sum(0, exp_obj), exp_sum(1, exp_obj), 0, 2);
    endtask

    task automatic test_overrun();
        int extra = 0;
        fill_random();
        run_update("overrun", exp_sum(0, exp_obj), exp_sum(1, exp_obj), 3, 0);
        for (int i = 0; i < 12; i++) begin
            if (commit !== 1'b0 || busy !== 1'b0) extra++;
            tick();
        end
        checks++;
        if (overrun !== 1'b1 || extra != 0) begin
            failures++;
            $display("FAIL overrun: overrun=%b extra_cycles=%0d, required 1/0", overrun, extra);
        end
        $display("overrun: flag=%b extra_cycles=%0d", overrun, extra);
    endtask

    task automatic test_back_to_back();
        int ncommit = 0;
        int nfd = 0;
        apply_reset();
        fill_random();
        step = 1'b1;
        for (int c = 1; c <= 10 * N; c++) begin
            tick();
            if (frame_done === 1'b1) nfd++;
            if (commit === 1'b1) begin
                checks++;
                if (c != 9 + 10 * ncommit || obj_sel !== 3'(ncommit) ||
                    x_force_sum !== exp_sum(0, ncommit) || y_force_sum !== exp_sum(1, ncommit) ||
                    frame_done !== (ncommit == N - 1)) begin
                    failures++;
                    $display("FAIL b2b_commit: cycle=%0d obj=%0d x=%h y=%h fd=%b, required cycle=%0d obj=%0d x=%h y=%h fd=%0d",
                             c, obj_sel, x_force_sum, y_force_sum, frame_done, 9 + 10 * ncommit,
                             ncommit, exp_sum(0, ncommit), exp_sum(1, ncommit), ncommit == N - 1);
                end
                $display("b2b commit: cycle=%0d obj=%0d x=%h y=%h fd=%b", c, obj_sel,
                         x_force_sum, y_force_sum, frame_done);
                ncommit++;
            end
        end
        step = 1'b0;
        checks++;
        if (ncommit != N || nfd != 1 || obj_sel !== 3'd0 || busy !== 1'b0 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL b2b_totals: commits=%0d fd=%0d obj=%0d busy=%b ovr=%b, required 8/1/0/0/1",
                     ncommit, nfd, obj_sel, busy, overrun);
        end
        exp_obj = 0;
    endtask

    task automatic test_reset_mid();
        int spurious = 0;
        apply_reset();
        fill_random();
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_obj = 0;
        checks++;
        if (busy !== 1'b0 || commit !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0 ||
            obj_sel !== 3'd0 || other_sel !== 3'd0 || x_force_sum !== 14'd0 || y_force_sum !== 14'd0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b commit=%b obj=%0d other=%0d x=%h y=%h, required all 0",
                     busy, commit, obj_sel, other_sel, x_force_sum, y_force_sum);
        end
        for (int i = 0; i < 12; i++) begin
            if (commit !== 1'b0 || busy !== 1'b0) spurious++;
            tick();
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL reset_mid_quiet: %0d active cycles, required 0", spurious);
        end
        $display("reset_mid: spurious=%0d", spurious);
    endtask

    initial begin
        fill_const(14'd0, 14'd0, 14'd0, 14'd0);
        test_reset();
        test_basic();
        test_self_skip();
        test_wrap();
        test_random();
        test_freeze_idle();
        test_freeze_mid();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
